// File: rtl/serial_addsub_mux_pkg.sv
// serial_addsub_mux_pkg: shared FSM encodings and counter sizing helpers
package serial_addsub_mux_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/serial_addsub_mux_if.sv
// serial_addsub_mux_if: start/done job handshake and operand/result bus
interface serial_addsub_mux_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (output start, sub, a, b, input busy, done, result, cout, overflow);
  modport slave  (input start, sub, a, b, output busy, done, result, cout, overflow);
endinterface

// File: rtl/serial_addsub_mux_fa_mux_cell.sv
// fa_mux_cell: full-adder cell built solely from six 2:1 multiplexers
module mux2 (
  input  logic i_sel,
  input  logic i_d0,
  input  logic i_d1,
  output logic o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

module fa_mux_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_co
);
  logic w_nb, w_s0, w_s1, w_co0, w_co1;

  assign w_nb = ~i_b;

  mux2 u_s0  (.i_sel(i_cin), .i_d0(i_b),  .i_d1(w_nb),  .o_y(w_s0));
  mux2 u_s1  (.i_sel(i_cin), .i_d0(w_nb), .i_d1(i_b),   .o_y(w_s1));
  mux2 u_s   (.i_sel(i_a),   .i_d0(w_s0), .i_d1(w_s1),  .o_y(o_s));
  mux2 u_co0 (.i_sel(i_cin), .i_d0(1'b0), .i_d1(i_b),   .o_y(w_co0));
  mux2 u_co1 (.i_sel(i_cin), .i_d0(i_b),  .i_d1(1'b1),  .o_y(w_co1));
  mux2 u_co  (.i_sel(i_a),   .i_d0(w_co0), .i_d1(w_co1), .o_y(o_co));
endmodule

// File: rtl/serial_addsub_mux.sv
// serial_addsub_mux: bit-serial add/sub, LSB first, through one mux-built full adder
module serial_addsub_mux
  import serial_addsub_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_addsub_mux_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN  = CW'(WIDTH - 2);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res_sh, r_result, w_res_nx;
  logic [CW-1:0]    r_cnt;
  logic             r_op, r_carry, r_c_msb, r_cout, r_ovf;
  logic             w_accept, w_last, w_s, w_co;

  assign w_accept = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

  fa_mux_cell u_fa (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0] ^ r_op),
    .i_cin(r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_nx = w_s;
    end else begin : g_wn
      assign w_res_nx = {w_s, r_res_sh[WIDTH-1:1]};
    end
  endgenerate

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;

  // next state: accept from IDLE/DONE, leave RUN after the MSB, otherwise rest in IDLE
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = w_accept ? ST_RUN :
                 (r_state == ST_RUN) ? (w_last ? ST_DONE : ST_RUN) : ST_IDLE;
  end

  // operand capture, per-bit shifting and result latching on the final bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_c_msb  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_op    <= bus.sub;
      r_carry <= bus.sub;
      r_c_msb <= bus.sub;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_nx;
      r_carry  <= w_co;
      r_cnt    <= r_cnt + 1'b1;
      if (WIDTH > 1 && r_cnt == PEN) r_c_msb <= w_co;
      if (w_last) begin
        r_result <= w_res_nx;
        r_cout   <= w_co;
        r_ovf    <= r_c_msb ^ w_co;
      end
    end

  assign bus.busy     = (r_state == ST_RUN);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.result   = r_result;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_addsub_mux.sv
// tb_serial_addsub_mux: directed and randomized checks of the serial add/sub block
module tb_serial_addsub_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  logic pd = 1'b0;
  logic pd1 = 1'b0;

  always #5 clk = ~clk;

  serial_addsub_mux_if #(.WIDTH(8)) ifc ();
  serial_addsub_mux_if #(.WIDTH(1)) ifc1 ();

  serial_addsub_mux #(.WIDTH(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifc));
  serial_addsub_mux #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

  always @(negedge clk) begin
    if (rst_n) begin
      chk_cnt++;
      if ((ifc.done && (ifc.busy || pd)) || (ifc1.done && (ifc1.busy || pd1)))
        $display("FAIL pulse: done=%b busy=%b prev_done=%b done1=%b busy1=%b prev_done1=%b required single-cycle done without busy",
                 ifc.done, ifc.busy, pd, ifc1.done, ifc1.busy, pd1);
      else pass_cnt++;
    end
    pd  = ifc.done;
    pd1 = ifc1.done;
  end

  task automatic do_job(input logic s, input logic [7:0] x, input logic [7:0] y, output int lat);
    @(negedge clk);
    ifc.start = 1'b1; ifc.sub = s; ifc.a = x; ifc.b = y;
    @(negedge clk);
    ifc.start = 1'b0;
    lat = 1;
    while (!ifc.done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #12;
    chk_cnt++;
    if ({ifc.busy, ifc.done, ifc.result, ifc.cout, ifc.overflow} !== 12'h0)
      $display("FAIL reset_during: got %h want 000", {ifc.busy, ifc.done, ifc.result, ifc.cout, ifc.overflow});
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({ifc.busy, ifc.done, ifc.result, ifc.cout, ifc.overflow} !== 12'h0)
      $display("FAIL reset_after: got %h want 000", {ifc.busy, ifc.done, ifc.result, ifc.cout, ifc.overflow});
    else pass_cnt++;
  endtask

  task automatic test_vectors;
    logic [7:0] va [6] = '{8'h0F, 8'h7F, 8'hFF, 8'h05, 8'h03, 8'h80};
    logic [7:0] vb [6] = '{8'h01, 8'h01, 8'h01, 8'h03, 8'h05, 8'h01};
    logic       vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] vr [6] = '{8'h10, 8'h80, 8'h00, 8'h02, 8'hFE, 8'h7F};
    logic       vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_job(vs[i], va[i], vb[i], lat);
      chk_cnt++;
      if (lat !== 9) $display("FAIL vec%0d_latency: got %0d want 9", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if ({ifc.result, ifc.cout, ifc.overflow} !== {vr[i], vc[i], vo[i]})
        $display("FAIL vec%0d_result: got r=%h c=%b v=%b want r=%h c=%b v=%b",
                 i, ifc.result, ifc.cout, ifc.overflow, vr[i], vc[i], vo[i]);
      else pass_cnt++;
    end
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({ifc.done, ifc.busy, ifc.result, ifc.cout, ifc.overflow} !== {2'b00, 8'h7F, 1'b1, 1'b1})
      $display("FAIL idle_hold: got d=%b b=%b r=%h c=%b v=%b want d=0 b=0 r=7f c=1 v=1",
               ifc.done, ifc.busy, ifc.result, ifc.cout, ifc.overflow);
    else pass_cnt++;
  endtask

  task automatic test_ignore;
    int lat;
    @(negedge clk);
    ifc.start = 1'b1; ifc.sub = 1'b0; ifc.a = 8'h10; ifc.b = 8'h20;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (ifc.busy !== 1'b1) $display("FAIL ignore_busy: got %b want 1", ifc.busy);
    else pass_cnt++;
    ifc.start = 1'b1; ifc.sub = 1'b1; ifc.a = 8'h55; ifc.b = 8'h55;
    @(negedge clk);
    ifc.start = 1'b0;
    lat = 3;
    while (!ifc.done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk_cnt++;
    if (lat !== 9) $display("FAIL ignore_latency: got %0d want 9", lat);
    else pass_cnt++;
    chk_cnt++;
    if ({ifc.result, ifc.cout, ifc.overflow} !== {8'h30, 1'b0, 1'b0})
      $display("FAIL ignore_result: got r=%h c=%b v=%b want r=30 c=0 v=0", ifc.result, ifc.cout, ifc.overflow);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (ifc.busy !== 1'b0) $display("FAIL ignore_not_queued: got busy=%b want 0", ifc.busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    ifc.start = 1'b1; ifc.sub = 1'b0; ifc.a = 8'h01; ifc.b = 8'h02;
    n = 0;
    while (!ifc.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if ({ifc.done, ifc.result} !== {1'b1, 8'h03}) $display("FAIL b2b_first: got d=%b r=%h want d=1 r=03", ifc.done, ifc.result);
    else pass_cnt++;
    ifc.sub = 1'b1; ifc.a = 8'h09; ifc.b = 8'h04;
    @(negedge clk);
    ifc.start = 1'b0;
    n = 1;
    while (!ifc.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (n !== 9) $display("FAIL b2b_spacing: got %0d want 9", n);
    else pass_cnt++;
    chk_cnt++;
    if ({ifc.result, ifc.cout, ifc.overflow} !== {8'h05, 1'b1, 1'b0})
      $display("FAIL b2b_second: got r=%h c=%b v=%b want r=05 c=1 v=0", ifc.result, ifc.cout, ifc.overflow);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int nd, lat;
    @(negedge clk);
    ifc.start = 1'b1; ifc.sub = 1'b0; ifc.a = 8'hFF; ifc.b = 8'h01;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (ifc.busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", ifc.busy);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({ifc.busy, ifc.done, ifc.result, ifc.cout, ifc.overflow} !== 12'h0)
      $display("FAIL midrst_outputs: got %h want 000", {ifc.busy, ifc.done, ifc.result, ifc.cout, ifc.overflow});
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(ifc.done) + int'(ifc.busy);
    end
    chk_cnt++;
    if (nd !== 0) $display("FAIL midrst_idle: got %0d done/busy cycles want 0", nd);
    else pass_cnt++;
    do_job(1'b0, 8'h12, 8'h34, lat);
    chk_cnt++;
    if ({lat[7:0], ifc.result, ifc.cout, ifc.overflow} !== {8'd9, 8'h46, 1'b0, 1'b0})
      $display("FAIL midrst_next_job: got lat=%0d r=%h c=%b v=%b want lat=9 r=46 c=0 v=0",
               lat, ifc.result, ifc.cout, ifc.overflow);
    else pass_cnt++;
  endtask

  task automatic test_width1;
    int lat, ua, ub, r, sr;
    logic er, ec, ev;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ifc1.start = 1'b1; ifc1.sub = i[2]; ifc1.a = i[1]; ifc1.b = i[0];
      @(negedge clk);
      ifc1.start = 1'b0;
      lat = 1;
      while (!ifc1.done && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      ua = i[1]; ub = i[0];
      r  = i[2] ? ua - ub : ua + ub;
      sr = i[2] ? ub - ua : -ua - ub;
      er = r[0];
      ec = i[2] ? (ua >= ub) : (r > 1);
      ev = (sr > 0) || (sr < -1);
      chk_cnt++;
      if ({lat[3:0], ifc1.result, ifc1.cout, ifc1.overflow} !== {4'd2, er, ec, ev})
        $display("FAIL w1_case%0d: got lat=%0d r=%b c=%b v=%b want lat=2 r=%b c=%b v=%b",
                 i, lat, ifc1.result, ifc1.cout, ifc1.overflow, er, ec, ev);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    int lat, ua, ub, r, sr;
    logic [7:0] x, y, er;
    logic s, ec, ev;
    for (int i = 0; i < 200; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      do_job(s, x, y, lat);
      ua = int'(x); ub = int'(y);
      r  = s ? ua - ub : ua + ub;
      sr = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
      er = 8'(r);
      ec = s ? (ua >= ub) : (r > 255);
      ev = (sr > 127) || (sr < -128);
      chk_cnt++;
      if ({lat[7:0], ifc.result, ifc.cout, ifc.overflow} !== {8'd9, er, ec, ev})
        $display("FAIL rand%0d %h%s%h: got lat=%0d r=%h c=%b v=%b want lat=9 r=%h c=%b v=%b",
                 i, x, s ? "-" : "+", y, lat, ifc.result, ifc.cout, ifc.overflow, er, ec, ev);
      else pass_cnt++;
    end
  endtask

  initial begin
    ifc.start = 1'b0; ifc.sub = 1'b0; ifc.a = '0; ifc.b = '0;
    ifc1.start = 1'b0; ifc1.sub = 1'b0; ifc1.a = '0; ifc1.b = '0;
    test_reset;
    test_vectors;
    test_ignore;
    test_back_to_back;
    test_reset_mid;
    test_width1;
    test_random;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
